// File: rtl/pong_game_ctrl_pkg.sv
// Shared game definitions: FSM state encodings, overlay text codes and defaults.
// The pixel generator imports the same text codes to decode text_sel.
package pong_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [1:0] TEXT_NONE  = 2'b00;
    localparam logic [1:0] TEXT_INTRO = 2'b01;
    localparam logic [1:0] TEXT_OVER  = 2'b10;

    localparam int BALLS_DEF        = 3;
    localparam int TIMER_FRAMES_DEF = 120;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// Button conditioner: 2-FF synchroniser plus rising-edge pulse per bit.
// Latency: pulse is visible 2 clk after the raw edge, consumed on the 3rd; no backpressure.
// Backpressure: none, the pulse lasts exactly one cycle per rising edge.
module pong_btn_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] button,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Driven only by flops, so the pulse is clean within the clk domain.
    assign rise = sync2 & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: phase FSM, balls remaining, BCD score, ball freeze and text overlay.
// Latency: all outputs registered, updated on the clk edge that takes the transition.
// Backpressure: none; hit/miss/frame_tick are single-cycle pulses consumed when relevant.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int BALLS        = BALLS_DEF,
    parameter int TIMER_FRAMES = TIMER_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] button,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [7:0] score_bcd,
    output logic [1:0] balls_left,
    output logic [1:0] text_sel,
    output logic [1:0] state
);

    localparam logic [1:0] BALLS_INIT = 2'(BALLS);
    localparam logic [7:0] TIMER_INIT = 8'(TIMER_FRAMES);

    state_t     st;
    logic [7:0] timer;
    logic [1:0] rise;
    logic       btn_ev;

    pong_btn_sync #(.WIDTH(2)) u_btn_sync (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .rise   (rise)
    );

    // Both buttons rising together collapse into a single event.
    assign btn_ev = |rise;
    assign state  = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= ST_IDLE;
            score_bcd  <= 8'h00;
            balls_left <= BALLS_INIT;
            gra_still  <= 1'b1;
            text_sel   <= TEXT_INTRO;
            timer      <= 8'd0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (btn_ev) begin
                        st         <= ST_PLAY;
                        score_bcd  <= 8'h00;
                        balls_left <= BALLS_INIT;
                        gra_still  <= 1'b0;
                        text_sel   <= TEXT_NONE;
                    end
                end
                ST_PLAY: begin
                    // A miss wins over a simultaneous hit: the ball is lost either way.
                    if (miss) begin
                        balls_left <= balls_left - 2'd1;
                        timer      <= TIMER_INIT;
                        gra_still  <= 1'b1;
                        if (balls_left == 2'd1) begin
                            st       <= ST_OVER;
                            text_sel <= TEXT_OVER;
                        end else begin
                            st       <= ST_NEWBALL;
                            text_sel <= TEXT_NONE;
                        end
                    end else if (hit) begin
                        score_bcd <= bcd_inc(score_bcd);
                    end
                end
                ST_NEWBALL: begin
                    if (frame_tick && timer != 8'd0)
                        timer <= timer - 8'd1;
                    // Decision uses the pre-decrement timer, so a press on the last tick is dropped.
                    if (btn_ev && timer == 8'd0) begin
                        st        <= ST_PLAY;
                        gra_still <= 1'b0;
                        text_sel  <= TEXT_NONE;
                    end
                end
                ST_OVER: begin
                    if (frame_tick) begin
                        if (timer != 8'd0)
                            timer <= timer - 8'd1;
                        if (timer <= 8'd1) begin
                            st       <= ST_IDLE;
                            text_sel <= TEXT_INTRO;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: table of PLAY vectors plus hand-written phase sequences.
module tb_pong_game_ctrl;
    import pong_game_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] button = 2'b00;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [7:0] score_bcd;
    logic [1:0] balls_left;
    logic [1:0] text_sel;
    logic [1:0] state;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic        hit;
        logic        miss;
        logic        tick;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs [14];

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .frame_tick (frame_tick),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .score_bcd  (score_bcd),
        .balls_left (balls_left),
        .text_sel   (text_sel),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] expv(input logic [1:0] s, input logic [7:0] sc,
                                         input logic [1:0] b, input logic still,
                                         input logic [1:0] t);
        return {s, sc, b, still, t};
    endfunction

    function automatic logic [14:0] outs();
        return {state, score_bcd, balls_left, gra_still, text_sel};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic press(input logic [1:0] mask);
        button = mask;
        repeat (5) step();
        button = 2'b00;
        repeat (3) step();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic do_hit(input int n);
        repeat (n) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
        end
    endtask

    task automatic do_miss();
        miss = 1'b1;
        step();
        miss = 1'b0;
    endtask

    initial begin
        int n;
        // PLAY vectors from score 00: a frame tick is ignored, then 12 hits with BCD carry.
        vecs[0]  = {3'b001, expv(ST_PLAY, 8'h00, 2'd3, 1'b0, TEXT_NONE)};
        vecs[1]  = {3'b100, expv(ST_PLAY, 8'h01, 2'd3, 1'b0, TEXT_NONE)};
        vecs[2]  = {3'b100, expv(ST_PLAY, 8'h02, 2'd3, 1'b0, TEXT_NONE)};
        vecs[3]  = {3'b100, expv(ST_PLAY, 8'h03, 2'd3, 1'b0, TEXT_NONE)};
        vecs[4]  = {3'b100, expv(ST_PLAY, 8'h04, 2'd3, 1'b0, TEXT_NONE)};
        vecs[5]  = {3'b000, expv(ST_PLAY, 8'h04, 2'd3, 1'b0, TEXT_NONE)};
        vecs[6]  = {3'b100, expv(ST_PLAY, 8'h05, 2'd3, 1'b0, TEXT_NONE)};
        vecs[7]  = {3'b100, expv(ST_PLAY, 8'h06, 2'd3, 1'b0, TEXT_NONE)};
        vecs[8]  = {3'b100, expv(ST_PLAY, 8'h07, 2'd3, 1'b0, TEXT_NONE)};
        vecs[9]  = {3'b100, expv(ST_PLAY, 8'h08, 2'd3, 1'b0, TEXT_NONE)};
        vecs[10] = {3'b100, expv(ST_PLAY, 8'h09, 2'd3, 1'b0, TEXT_NONE)};
        vecs[11] = {3'b101, expv(ST_PLAY, 8'h10, 2'd3, 1'b0, TEXT_NONE)};
        vecs[12] = {3'b100, expv(ST_PLAY, 8'h11, 2'd3, 1'b0, TEXT_NONE)};
        vecs[13] = {3'b100, expv(ST_PLAY, 8'h12, 2'd3, 1'b0, TEXT_NONE)};

        // Reset values while reset is held low.
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(state), 32'(ST_IDLE));
        chk("reset_score", 32'(score_bcd), 32'h00);
        chk("reset_balls", 32'(balls_left), 32'd3);
        chk("reset_still", 32'(gra_still), 32'd1);
        chk("reset_text", 32'(text_sel), 32'(TEXT_INTRO));
        reset = 1'b1;
        step();

        // Start: button[0] held 5 clk, state change 3 clk after the raw edge.
        button = 2'b01;
        n = 0;
        while (state != ST_PLAY && n < 8) begin
            step();
            n++;
        end
        chk("start_latency", n, 32'd3);
        repeat (2) step();
        button = 2'b00;
        repeat (3) step();
        chk("start_outs", 32'(outs()), 32'(expv(ST_PLAY, 8'h00, 2'd3, 1'b0, TEXT_NONE)));

        for (int i = 0; i < 14; i++) begin
            hit        = vecs[i].hit;
            miss       = vecs[i].miss;
            frame_tick = vecs[i].tick;
            step();
            hit        = 1'b0;
            miss       = 1'b0;
            frame_tick = 1'b0;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // 99 then wrap to 00, then build up to 05.
        do_hit(87);
        chk("score_99", 32'(score_bcd), 32'h99);
        do_hit(1);
        chk("score_wrap", 32'(score_bcd), 32'h00);
        do_hit(5);

        // Hit and miss together: miss wins, score kept.
        hit  = 1'b1;
        miss = 1'b1;
        step();
        hit  = 1'b0;
        miss = 1'b0;
        chk("hit_miss", 32'(outs()), 32'(expv(ST_NEWBALL, 8'h05, 2'd2, 1'b1, TEXT_NONE)));

        // NEWBALL hold: early press dropped.
        ticks(60);
        press(2'b01);
        chk("newball_early_btn", 32'(state), 32'(ST_NEWBALL));
        ticks(59);
        // Button edge lands on the same cycle as the tick taking timer 1->0.
        button = 2'b10;
        repeat (2) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("newball_tick_btn", 32'(state), 32'(ST_NEWBALL));
        repeat (2) step();
        button = 2'b00;
        repeat (3) step();
        chk("newball_not_queued", 32'(state), 32'(ST_NEWBALL));
        press(2'b01);
        chk("newball_resume", 32'(outs()), 32'(expv(ST_PLAY, 8'h05, 2'd2, 1'b0, TEXT_NONE)));

        // Asynchronous reset between clock edges mid-PLAY.
        do_hit(7);
        chk("pre_reset_score", 32'(score_bcd), 32'h12);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'(expv(ST_IDLE, 8'h00, 2'd3, 1'b1, TEXT_INTRO)));
        step();
        reset = 1'b1;
        step();
        press(2'b11);
        chk("dual_btn_start", 32'(outs()), 32'(expv(ST_PLAY, 8'h00, 2'd3, 1'b0, TEXT_NONE)));

        // Three misses to OVER, then the hold back to IDLE.
        do_hit(3);
        do_miss();
        chk("miss1", 32'(outs()), 32'(expv(ST_NEWBALL, 8'h03, 2'd2, 1'b1, TEXT_NONE)));
        ticks(120);
        press(2'b01);
        do_miss();
        chk("miss2", 32'(outs()), 32'(expv(ST_NEWBALL, 8'h03, 2'd1, 1'b1, TEXT_NONE)));
        ticks(120);
        press(2'b10);
        chk("resume2", 32'(state), 32'(ST_PLAY));
        do_miss();
        chk("over_entry", 32'(outs()), 32'(expv(ST_OVER, 8'h03, 2'd0, 1'b1, TEXT_OVER)));
        press(2'b01);
        chk("over_btn_ignored", 32'(state), 32'(ST_OVER));
        do_hit(1);
        chk("over_hit_ignored", 32'(score_bcd), 32'h03);
        ticks(119);
        chk("over_hold", 32'(state), 32'(ST_OVER));
        ticks(1);
        chk("over_to_idle", 32'(outs()), 32'(expv(ST_IDLE, 8'h03, 2'd0, 1'b1, TEXT_INTRO)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
